// File: rtl/game_sequencer.sv
// Game-flow controller: level/lives registers, phase FSM, level-scaled car step strobe, frog reset pulse.
// Latency: input sampled in cycle N is reflected in registered state/outputs in cycle N+1.
// Backpressure: none; inputs are level signals, outputs are strobes/levels with no handshake.
module game_sequencer #(
    parameter int TICK_BASE   = 900000,
    parameter int TICK_DEC    = 50000,
    parameter int TICK_MIN    = 200000,
    parameter int MAX_LEVEL   = 15,
    parameter int START_LIVES = 3,
    parameter int DEATH_HOLD  = 25000000,
    parameter int WIN_HOLD    = 12500000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_Start,
    input  logic       i_Frog_At_Top,
    input  logic       i_Collision,
    output logic [2:0] o_State,
    output logic [3:0] o_Level,
    output logic [1:0] o_Lives,
    output logic       o_Car_Step,
    output logic       o_Frog_Reset,
    output logic       o_Freeze,
    output logic       o_Game_Over
);

    localparam logic [2:0] ST_ATTRACT   = 3'd0;
    localparam logic [2:0] ST_PLAY      = 3'd1;
    localparam logic [2:0] ST_DYING     = 3'd2;
    localparam logic [2:0] ST_LEVEL_UP  = 3'd3;
    localparam logic [2:0] ST_GAME_OVER = 3'd4;

    localparam int HOLD_MAX = (DEATH_HOLD > WIN_HOLD) ? DEATH_HOLD : WIN_HOLD;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    localparam logic [HOLD_W-1:0] DEATH_LAST = HOLD_W'(DEATH_HOLD - 1);
    localparam logic [HOLD_W-1:0] WIN_LAST   = HOLD_W'(WIN_HOLD - 1);
    localparam logic [23:0]       BASE24     = 24'(TICK_BASE);
    localparam logic [23:0]       DEC24      = 24'(TICK_DEC);
    localparam logic [23:0]       MIN24      = 24'(TICK_MIN);
    localparam logic [3:0]        LVL_MAX    = 4'(MAX_LEVEL);
    localparam logic [1:0]        LIVES_INIT = 2'(START_LIVES);

    logic              start_q;
    logic              start_rise;
    logic              input_mask;
    logic [23:0]       step_cnt;
    logic [23:0]       step_cnt_n;
    logic [23:0]       dec_amt;
    logic [23:0]       period;
    logic [23:0]       step_last;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_n;
    logic [2:0]        state_n;
    logic [3:0]        level_n;
    logic [1:0]        lives_n;
    logic              car_step_n;
    logic              frog_reset_n;

    assign start_rise = i_Start & ~start_q;
    // Frog position is stale during the reset pulse cycle, so ignore its reports then.
    assign input_mask = o_Frog_Reset;

    // Clamp before subtracting so the period can never wrap below the floor.
    always_comb begin
        dec_amt = {20'd0, o_Level - 4'd1} * DEC24;
        if ((BASE24 <= MIN24) || (dec_amt >= (BASE24 - MIN24))) begin
            period = MIN24;
        end else begin
            period = BASE24 - dec_amt;
        end
        step_last = period - 24'd1;
    end

    always_comb begin
        state_n      = o_State;
        level_n      = o_Level;
        lives_n      = o_Lives;
        step_cnt_n   = step_cnt;
        hold_cnt_n   = hold_cnt;
        car_step_n   = 1'b0;
        frog_reset_n = 1'b0;

        if (start_rise) begin
            state_n      = ST_PLAY;
            level_n      = 4'd1;
            lives_n      = LIVES_INIT;
            step_cnt_n   = '0;
            hold_cnt_n   = '0;
            frog_reset_n = 1'b1;
        end else begin
            case (o_State)
                ST_ATTRACT: begin
                    state_n = ST_ATTRACT;
                end
                ST_PLAY: begin
                    if (!input_mask && i_Collision) begin
                        hold_cnt_n = '0;
                        if (o_Lives <= 2'd1) begin
                            state_n = ST_GAME_OVER;
                            lives_n = 2'd0;
                        end else begin
                            state_n = ST_DYING;
                            lives_n = o_Lives - 2'd1;
                        end
                    end else if (!input_mask && i_Frog_At_Top) begin
                        state_n    = ST_LEVEL_UP;
                        hold_cnt_n = '0;
                        level_n    = (o_Level >= LVL_MAX) ? LVL_MAX : o_Level + 4'd1;
                    end else if (step_cnt >= step_last) begin
                        step_cnt_n = '0;
                        car_step_n = 1'b1;
                    end else begin
                        step_cnt_n = step_cnt + 24'd1;
                    end
                end
                ST_DYING: begin
                    if (hold_cnt == DEATH_LAST) begin
                        state_n      = ST_PLAY;
                        hold_cnt_n   = '0;
                        frog_reset_n = 1'b1;
                    end else begin
                        hold_cnt_n = hold_cnt + 1'b1;
                    end
                end
                ST_LEVEL_UP: begin
                    if (hold_cnt == WIN_LAST) begin
                        state_n      = ST_PLAY;
                        hold_cnt_n   = '0;
                        step_cnt_n   = '0;
                        frog_reset_n = 1'b1;
                    end else begin
                        hold_cnt_n = hold_cnt + 1'b1;
                    end
                end
                ST_GAME_OVER: begin
                    lives_n = 2'd0;
                end
                default: begin
                    state_n    = ST_ATTRACT;
                    step_cnt_n = '0;
                    hold_cnt_n = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_State      <= ST_ATTRACT;
            o_Level      <= 4'd1;
            o_Lives      <= LIVES_INIT;
            o_Car_Step   <= 1'b0;
            o_Frog_Reset <= 1'b0;
            o_Freeze     <= 1'b1;
            o_Game_Over  <= 1'b0;
            step_cnt     <= '0;
            hold_cnt     <= '0;
            start_q      <= 1'b0;
        end else begin
            o_State      <= state_n;
            o_Level      <= level_n;
            o_Lives      <= lives_n;
            o_Car_Step   <= car_step_n;
            o_Frog_Reset <= frog_reset_n;
            o_Freeze     <= (state_n != ST_PLAY);
            o_Game_Over  <= (state_n == ST_GAME_OVER);
            step_cnt     <= step_cnt_n;
            hold_cnt     <= hold_cnt_n;
            start_q      <= i_Start;
        end
    end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Central game-flow controller for the frog/car playfield. It sits between the debounced switches, the frog/collision logic and the car movers. It owns the level and lives registers and sequences attract, play, death, level-up and game-over phases. It also replaces the free-running car clock divider with a level-scaled single-cycle car step enable, and issues frog reset pulses.

## Interface
- TICK_BASE, 900000: clocks per car step at level 1.
- TICK_DEC, 50000: step period reduction per level above 1.
- TICK_MIN, 200000: floor on the step period.
- MAX_LEVEL, 15: level saturation value, 4-bit.
- START_LIVES, 3: lives at game start, 1..3.
- DEATH_HOLD, 25000000: freeze cycles after a collision.
- WIN_HOLD, 12500000: freeze cycles after reaching the top.
- i_Clk  in  1  system clock (25 MHz).
- i_Rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- i_Start  in  1  debounced all-four-switches combo, level; only its rising edge acts.
- i_Frog_At_Top  in  1  frog occupies the goal row, level.
- i_Collision  in  1  frog overlaps a car, level.
- o_State  out  3  0=ATTRACT, 1=PLAY, 2=DYING, 3=LEVEL_UP, 4=GAME_OVER.
- o_Level  out  4  current level, 1..MAX_LEVEL.
- o_Lives  out  2  remaining lives.
- o_Car_Step  out  1  single-cycle car advance strobe.
- o_Frog_Reset  out  1  single-cycle pulse returning the frog to its start cell.
- o_Freeze  out  1  high when frog movement must be ignored.
- o_Game_Over  out  1  high in GAME_OVER.

## Operation
- Reset values: state ATTRACT, o_Level=1, o_Lives=START_LIVES, o_Car_Step=0, o_Frog_Reset=0, o_Freeze=1, o_Game_Over=0. The step counter, hold counter and start-edge register are all cleared.
- Start edge: a registered copy of i_Start; start_rise = i_Start & ~prev.
- Game start: on start_rise in any state, the next state is PLAY. Level becomes 1, lives become START_LIVES, step and hold counters clear, and o_Frog_Reset pulses. Start has the highest priority.
- ATTRACT: freeze, no steps; waits for start_rise.
- PLAY:
  - o_Freeze=0.
  - Step counter increments each cycle. When it reaches period-1, o_Car_Step=1 and the counter returns to 0.
  - period = max(TICK_MIN, TICK_BASE - (level-1)*TICK_DEC), computed in 24-bit unsigned arithmetic. Underflow must not occur; clamp before subtracting.
  - i_Collision=1 decrements lives. If the old lives value was 1, go to GAME_OVER with lives 0. Otherwise go to DYING.
  - Otherwise i_Frog_At_Top=1 goes to LEVEL_UP.
  - Collision beats at-top in the same cycle.
  - Both inputs are ignored during the cycle in which o_Frog_Reset is high, to mask stale frog position.
- DYING: freeze, no steps, step counter holds. After DEATH_HOLD cycles, go to PLAY and pulse o_Frog_Reset.
- LEVEL_UP: on entry, level = min(level+1, MAX_LEVEL). Freeze, no steps. After WIN_HOLD cycles, go to PLAY, pulse o_Frog_Reset, and clear the step counter.
- GAME_OVER: freeze, o_Game_Over=1, lives remain 0, level holds for display. Only start_rise leaves this state.
- Illegal state encodings return to ATTRACT.

## Timing
- All outputs are registered. A decision on an input sampled in cycle N appears in state and outputs in cycle N+1.
- o_Frog_Reset is high exactly in the first PLAY cycle after ATTRACT, DYING, LEVEL_UP or GAME_OVER, or after a restart from PLAY.
- Hold counters run 0..HOLD-1, so a hold state lasts exactly HOLD cycles.
- First o_Car_Step occurs `period` cycles after entry to PLAY with a cleared counter.
- o_Car_Step is never high outside PLAY.
- Asynchronous reset mid-game returns to the reset values immediately, independent of i_Clk.

## Test plan
Unless stated, use TICK_BASE=10, TICK_DEC=2, TICK_MIN=4, DEATH_HOLD=5, WIN_HOLD=3, START_LIVES=3.
- Reset then start: release i_Rst_n, pulse i_Start -> next cycle state 1, o_Frog_Reset=1 for one cycle, level 1, lives 3. o_Car_Step pulses every 10 cycles.
- Level scaling: reach the top 4 times -> level 5, step period 4 (floor; 10-8=2 is clamped). At MAX_LEVEL=15, a further top event keeps level 15.
- Death sequence: collision in PLAY -> lives 2, state 2 for 5 cycles with no steps, then PLAY with a frog reset pulse. Repeat twice -> third collision gives state 4, lives 0, o_Game_Over=1.
- Simultaneous events: i_Collision and i_Frog_At_Top high in the same cycle -> DYING, level unchanged. i_Start rising in that same cycle -> restart to PLAY instead, with level 1 and lives 3.
- Held start: i_Start held high for 100 cycles in GAME_OVER -> exactly one restart. Stale at-top during the frog-reset cycle -> ignored.
- Mid-hold reset: assert i_Rst_n low during LEVEL_UP -> asynchronously state 0, level 1, lives 3, o_Freeze=1.
